tlb_cache: RTL and testbench

Parametrised, fully associative, clocked translation lookaside buffer. It translates virtual addresses to physical addresses for the memory front end. On a miss it runs a handshaked page-table walk, installs the result using clock (second-chance) replacement, and reports page faults. It tracks referenced and dirty bits and supports a single-cycle flush.

---
 rtl/tlb_cache.sv | 128 ++++++++++++
 tb/tb_tlb_cache.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tlb_cache.sv
// tlb_cache: fully associative TLB with handshaked page-table walk, clock (second-chance)
// replacement, referenced/dirty tracking, page-fault reporting and single-cycle flush.
module tlb_cache #(
    parameter int VA_W    = 12,
    parameter int OFF_W   = 4,
    parameter int PPN_W   = 6,
    parameter int ENTRIES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [VA_W-1:0]         req_va,
    input  logic                    req_write,
    output logic                    resp_valid,
    output logic [PPN_W+OFF_W-1:0]  resp_pa,
    output logic                    resp_hit,
    output logic                    resp_fault,
    output logic                    pt_req,
    output logic [VA_W-OFF_W-1:0]   pt_vpn,
    input  logic                    pt_ack,
    input  logic [PPN_W-1:0]        pt_ppn,
    input  logic                    pt_valid,
    input  logic                    flush,
    input  logic                    clear_refer
);
    localparam int VPN_W = VA_W - OFF_W;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, WALK, FILL} state_t;
    state_t state, state_n;

    logic [VPN_W-1:0]   tag [ENTRIES];
    logic [PPN_W-1:0]   ppn [ENTRIES];
    logic [ENTRIES-1:0] valid, refer, dirty, match;
    logic [IDX_W-1:0]   hand, hit_idx, inv_idx, clk_idx, victim;
    logic [VA_W-1:0]    va_q;
    logic [PPN_W-1:0]   ppn_q;
    logic               wr_q, pv_q, hit, inv_any, install;

    // Descending scans leave the lowest match/invalid index and the first unreferenced
    // entry at or after the hand; clk_idx stays at the hand when every entry is referenced.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        inv_idx = '0;
        clk_idx = hand;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            match[i] = valid[i] && tag[i] == req_va[VA_W-1:OFF_W];
            if (match[i]) hit_idx = IDX_W'(i);
            if (!valid[i]) inv_idx = IDX_W'(i);
            if (!refer[hand + IDX_W'(i)]) clk_idx = hand + IDX_W'(i);
        end
    end

    assign inv_any = ~&valid;
    assign victim  = inv_any ? inv_idx : clk_idx;
    assign hit     = state == IDLE && req_valid && |match && !flush;
    assign install = state == FILL && pv_q && !flush;
    assign pt_vpn  = va_q[VA_W-1:OFF_W];

    always_comb begin
        req_ready = state == IDLE;
        pt_req    = state == WALK;
        state_n   = state == IDLE ? ((req_valid && !hit) ? WALK : IDLE)
                  : state == WALK ? (pt_ack ? FILL : WALK) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            refer      <= '0;
            dirty      <= '0;
            hand       <= '0;
            va_q       <= '0;
            wr_q       <= 1'b0;
            ppn_q      <= '0;
            pv_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_pa    <= '0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
        end else begin
            state      <= state_n;
            resp_valid <= 1'b0;
            if (clear_refer) refer <= '0;
            if (state == IDLE && req_valid) begin
                va_q <= req_va;
                wr_q <= req_write;
            end
            if (state == WALK && pt_ack) begin
                ppn_q <= pt_ppn;
                pv_q  <= pt_valid;
            end
            if (hit) begin
                refer[hit_idx] <= 1'b1;
                if (req_write) dirty[hit_idx] <= 1'b1;
                resp_valid <= 1'b1;
                resp_hit   <= 1'b1;
                resp_fault <= 1'b0;
                resp_pa    <= {ppn[hit_idx], req_va[OFF_W-1:0]};
            end
            if (state == FILL) begin
                resp_valid <= 1'b1;
                resp_hit   <= 1'b0;
                resp_fault <= !pv_q;
                resp_pa    <= pv_q ? {ppn_q, va_q[OFF_W-1:0]} : '0;
            end
            // Later bit writes override the bulk clear, so the new entry keeps its refer bit.
            if (install) begin
                valid[victim] <= 1'b1;
                dirty[victim] <= wr_q;
                if (!inv_any) hand <= victim + 1'b1;
                if (!inv_any && &refer) refer <= '0;
                refer[victim] <= 1'b1;
            end
            if (flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag[victim] <= va_q[VA_W-1:OFF_W];
            ppn[victim] <= ppn_q;
        end
    end
endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: directed self-checking bench for tlb_cache (hits, walks, faults,
// clock replacement, dirty tracking, flush and mid-walk reset).
module tb_tlb_cache;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_write, pt_ack, pt_valid, flush, clear_refer;
    logic        req_ready, resp_valid, resp_hit, resp_fault, pt_req;
    logic [11:0] req_va;
    logic [9:0]  resp_pa;
    logic [7:0]  pt_vpn;
    logic [5:0]  pt_ppn;
    int          total = 0;
    int          passed = 0;

    tlb_cache dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_va(req_va), .req_write(req_write), .resp_valid(resp_valid), .resp_pa(resp_pa),
        .resp_hit(resp_hit), .resp_fault(resp_fault), .pt_req(pt_req), .pt_vpn(pt_vpn),
        .pt_ack(pt_ack), .pt_ppn(pt_ppn), .pt_valid(pt_valid), .flush(flush),
        .clear_refer(clear_refer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    endtask

    // fl: 0 none, 1 flush with the request, 2 flush in the FILL cycle
    task automatic xlate(input string t, input logic [11:0] va, input logic wr, input int dly,
                         input logic [5:0] ppn, input logic pv, input int fl,
                         input logic eh, input logic [9:0] epa, input logic ef);
        req_valid = 1'b1;
        req_va    = va;
        req_write = wr;
        flush     = fl == 1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        chk({t, "/early_resp"}, resp_valid, eh);
        if (!resp_valid) begin
            chk({t, "/pt_req"}, pt_req, 1);
            chk({t, "/pt_vpn"}, pt_vpn, va[11:4]);
            repeat (dly) @(negedge clk);
            pt_ack   = 1'b1;
            pt_ppn   = ppn;
            pt_valid = pv;
            @(negedge clk);
            pt_ack = 1'b0;
            flush  = fl == 2;
            @(negedge clk);
            flush = 1'b0;
        end
        chk({t, "/resp_valid"}, resp_valid, 1);
        chk({t, "/resp_hit"}, resp_hit, eh);
        chk({t, "/resp_fault"}, resp_fault, ef);
        chk({t, "/resp_pa"}, resp_pa, epa);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_va = '0; pt_ack = 1'b0;
        pt_valid = 1'b0; pt_ppn = '0; flush = 1'b0; clear_refer = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/req_ready", req_ready, 1);
        chk("rst/resp_valid", resp_valid, 0);
        chk("rst/resp_hit", resp_hit, 0);
        chk("rst/resp_fault", resp_fault, 0);
        chk("rst/resp_pa", resp_pa, 0);
        chk("rst/pt_req", pt_req, 0);
        chk("rst/pt_vpn", pt_vpn, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xlate("miss123", 12'h123, 0, 3, 6'h2A, 1, 0, 0, 10'h2A3, 0);
        xlate("hit125", 12'h125, 0, 0, 6'h00, 1, 0, 1, 10'h2A5, 0);
        @(negedge clk);
        chk("hold/resp_valid", resp_valid, 0);
        chk("hold/resp_pa", resp_pa, 10'h2A5);
        chk("hold/resp_hit", resp_hit, 1);

        xlate("fault456", 12'h456, 0, 1, 6'h3F, 0, 0, 0, 10'h000, 1);
        xlate("retry456", 12'h456, 0, 2, 6'h11, 1, 0, 0, 10'h116, 0);
        xlate("miss789", 12'h789, 0, 0, 6'h05, 1, 0, 0, 10'h059, 0);
        xlate("missABC", 12'hABC, 0, 1, 6'h3F, 1, 0, 0, 10'h3FC, 0);
        pulse_flush();
        chk("flush/valid", dut.valid, 0);
        xlate("pf123", 12'h123, 0, 0, 6'h2A, 1, 0, 0, 10'h2A3, 0);
        xlate("pf789", 12'h789, 0, 1, 6'h05, 1, 0, 0, 10'h059, 0);
        xlate("flreq125", 12'h125, 0, 0, 6'h2A, 1, 1, 0, 10'h2A5, 0);
        xlate("flfill300", 12'h300, 0, 1, 6'h07, 1, 2, 0, 10'h070, 0);
        chk("flfill/valid", dut.valid, 0);
        xlate("re300", 12'h300, 0, 0, 6'h07, 1, 0, 0, 10'h070, 0);
        pulse_flush();
        chk("flush2/valid", dut.valid, 0);
        chk("flush2/hand", dut.hand, 0);

        for (int k = 0; k < 16; k++)
            xlate("fill16", {k[7:0], 4'h7}, 0, k % 3, 6'h20 | 6'(k), 1, 0, 0,
                  {6'h20 | 6'(k), 4'h7}, 0);
        chk("full/valid", dut.valid, 16'hFFFF);
        chk("full/refer", dut.refer, 16'hFFFF);
        xlate("evict10", 12'h107, 0, 0, 6'h30, 1, 0, 0, 10'h307, 0);
        chk("evict10/hand", dut.hand, 1);
        chk("evict10/refer", dut.refer, 16'h0001);
        xlate("hit01", 12'h017, 0, 0, 6'h00, 1, 0, 1, 10'h217, 0);
        xlate("miss00", 12'h007, 0, 1, 6'h20, 1, 0, 0, 10'h207, 0);
        chk("miss00/hand", dut.hand, 3);
        xlate("miss02", 12'h027, 0, 0, 6'h22, 1, 0, 0, 10'h227, 0);
        chk("miss02/hand", dut.hand, 4);
        xlate("hit10", 12'h107, 0, 0, 6'h00, 1, 0, 1, 10'h307, 0);

        xlate("whit05", 12'h057, 1, 0, 6'h00, 1, 0, 1, 10'h257, 0);
        chk("whit05/dirty5", dut.dirty[5], 1);
        xlate("rhit05", 12'h05A, 0, 0, 6'h00, 1, 0, 1, 10'h25A, 0);
        chk("rhit05/dirty5", dut.dirty[5], 1);
        xlate("wmiss20", 12'h207, 1, 2, 6'h01, 1, 0, 0, 10'h017, 0);
        chk("wmiss20/dirty4", dut.dirty[4], 1);
        chk("wmiss20/hand", dut.hand, 5);
        clear_refer = 1'b1;
        @(negedge clk);
        clear_refer = 1'b0;
        chk("clr/refer", dut.refer, 0);

        req_valid = 1'b1;
        req_va    = 12'h999;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw/pt_req", pt_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rw/async_ready", req_ready, 1);
        chk("rw/async_pt_req", pt_req, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        pt_ack   = 1'b1;
        pt_valid = 1'b1;
        pt_ppn   = 6'h15;
        @(negedge clk);
        pt_ack = 1'b0;
        chk("rw/resp_valid", resp_valid, 0);
        chk("rw/req_ready", req_ready, 1);
        chk("rw/valid", dut.valid, 0);
        @(negedge clk);
        chk("rw/resp_valid2", resp_valid, 0);
        chk("rw/pt_req2", pt_req, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
